// File: rtl/address_decoder.sv
// CPU address decoder: combinational region selects plus one-clk, active-low registered
// write strobes. Define ADDRDEC_UART_EN to build the UARTn strobe, otherwise UARTn is tied high.
module address_decoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce2H,
    input  logic        ce2Hd,
    input  logic [15:0] BA,
    input  logic        BRWn,
    output logic        NRn,
    output logic        ROM0n,
    output logic        ROM1n,
    output logic        ROM2n,
    output logic        SBUSn,
    output logic        SRAMn,
    output logic        NVRAMn,
    output logic        IN0n,
    output logic        CIOn,
    output logic        BITMDn,
    output logic        WDOGn,
    output logic        INTACKn,
    output logic        VSLDn,
    output logic        HSLDn,
    output logic        OUT0n,
    output logic        OUT1n,
    output logic        CRAMn,
    output logic        XCOORDn,
    output logic        YCOORDn,
    output logic        UARTn
);

    logic       unused_ce2h;
    logic       io_page;
    logic       wr_qual;
    logic [8:0] strb_hit;
    logic [8:0] strb_d;
    logic [8:0] strb_q;

    // ce2H is kept only for interface compatibility.
    assign unused_ce2h = ce2H;

    assign NRn    = BA[15] & (BA[14] | BA[13]);
    assign ROM0n  = ~(BA[15:13] == 3'b101);
    assign ROM1n  = ~(BA[15:13] == 3'b110);
    assign ROM2n  = ~(BA[15:13] == 3'b111);
    assign SBUSn  = ~(BA[15:13] == 3'b100);
    assign SRAMn  = ~(BA[15:12] == 4'h8);
    assign NVRAMn = ~(BA[15:10] == 6'b100100);
    assign IN0n   = ~(BA[15:10] == 6'b100101);
    assign CIOn   = ~(BA[15:10] == 6'b100110);
    assign BITMDn = ~(BA == 16'h0002);

    // 9C00-9FFF is split into eight 128-byte strobe windows by BA[9:7].
    assign io_page = (BA[15:10] == 6'b100111);
    assign wr_qual = ce2Hd & ~BRWn;

    always_comb begin
        strb_hit    = '0;
        strb_hit[8] = io_page && (BA[9:7] == 3'b100);
        strb_hit[7] = io_page && (BA[9:7] == 3'b011);
        strb_hit[6] = io_page && (BA[9:7] == 3'b010);
        strb_hit[5] = io_page && (BA[9:7] == 3'b001);
        strb_hit[4] = io_page && (BA[9:7] == 3'b101);
        strb_hit[3] = io_page && (BA[9:7] == 3'b110);
        strb_hit[2] = io_page && (BA[9:7] == 3'b111);
        strb_hit[1] = (BA == 16'h0000);
        strb_hit[0] = (BA == 16'h0001);
        strb_d      = ~(strb_hit & {9{wr_qual}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_q <= '1;
        end else begin
            strb_q <= strb_d;
        end
    end

    assign WDOGn   = strb_q[8];
    assign INTACKn = strb_q[7];
    assign VSLDn   = strb_q[6];
    assign HSLDn   = strb_q[5];
    assign OUT0n   = strb_q[4];
    assign OUT1n   = strb_q[3];
    assign CRAMn   = strb_q[2];
    assign XCOORDn = strb_q[1];
    assign YCOORDn = strb_q[0];

`ifdef ADDRDEC_UART_EN
    logic uart_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uart_q <= 1'b1;
        end else begin
            uart_q <= ~(io_page && (BA[9:7] == 3'b000) && wr_qual);
        end
    end

    assign UARTn = uart_q;
`else
    assign UARTn = 1'b1;
`endif

endmodule

// File: tb/tb_address_decoder.sv
// Directed self-checking bench for address_decoder; honours ADDRDEC_UART_EN when defined.
module tb_address_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce2H = 1'b0;
    logic        ce2Hd = 1'b0;
    logic [15:0] BA = 16'h0000;
    logic        BRWn = 1'b1;
    logic NRn, ROM0n, ROM1n, ROM2n, SBUSn, SRAMn, NVRAMn, IN0n, CIOn, BITMDn;
    logic WDOGn, INTACKn, VSLDn, HSLDn, OUT0n, OUT1n, CRAMn, XCOORDn, YCOORDn, UARTn;

    int checks = 0;
    int errors = 0;

    // Strobe indices: 9 WDOG, 8 INTACK, 7 VSLD, 6 HSLD, 5 OUT0, 4 OUT1, 3 CRAM, 2 X, 1 Y, 0 UART.
    localparam int NoStrb = -1;
`ifdef ADDRDEC_UART_EN
    localparam int UartIdx = 0;
`else
    localparam int UartIdx = NoStrb;
`endif

    always #50 clk = ~clk;

    address_decoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce2H    (ce2H),
        .ce2Hd   (ce2Hd),
        .BA      (BA),
        .BRWn    (BRWn),
        .NRn     (NRn),
        .ROM0n   (ROM0n),
        .ROM1n   (ROM1n),
        .ROM2n   (ROM2n),
        .SBUSn   (SBUSn),
        .SRAMn   (SRAMn),
        .NVRAMn  (NVRAMn),
        .IN0n    (IN0n),
        .CIOn    (CIOn),
        .BITMDn  (BITMDn),
        .WDOGn   (WDOGn),
        .INTACKn (INTACKn),
        .VSLDn   (VSLDn),
        .HSLDn   (HSLDn),
        .OUT0n   (OUT0n),
        .OUT1n   (OUT1n),
        .CRAMn   (CRAMn),
        .XCOORDn (XCOORDn),
        .YCOORDn (YCOORDn),
        .UARTn   (UARTn)
    );

    function automatic logic [9:0] comb_vec();
        return {NRn, ROM0n, ROM1n, ROM2n, SBUSn, SRAMn, NVRAMn, IN0n, CIOn, BITMDn};
    endfunction

    function automatic logic [9:0] strb_vec();
        return {WDOGn, INTACKn, VSLDn, HSLDn, OUT0n, OUT1n, CRAMn, XCOORDn, YCOORDn, UARTn};
    endfunction

    function automatic logic [9:0] strb_exp(input int idx);
        logic [9:0] v;
        v = 10'h3FF;
        if (idx >= 0) v[idx] = 1'b0;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read access with ce2Hd pulsed: checks selects and that no strobe fires.
    task automatic do_read(input logic [15:0] addr, input logic [9:0] exp_comb);
        @(negedge clk);
        BA = addr; BRWn = 1'b1; ce2Hd = 1'b1;
        #1 check($sformatf("comb_rd_%h", addr), {22'd0, comb_vec()}, {22'd0, exp_comb});
        @(posedge clk); #1;
        check($sformatf("strb_rd_%h", addr), {22'd0, strb_vec()}, {22'd0, 10'h3FF});
        ce2Hd = 1'b0;
    endtask

    // Write access with ce2Hd for one clk: strobe idx low for that clk, then high again.
    task automatic do_write(input logic [15:0] addr, input int idx);
        @(negedge clk);
        BA = addr; BRWn = 1'b0; ce2Hd = 1'b1;
        @(posedge clk); #1;
        check($sformatf("strb_wr_%h", addr), {22'd0, strb_vec()}, {22'd0, strb_exp(idx)});
        ce2Hd = 1'b0;
        @(posedge clk); #1;
        check($sformatf("strb_end_%h", addr), {22'd0, strb_vec()}, {22'd0, 10'h3FF});
    endtask

    initial begin
        // Reset held: qualifying write must not produce a strobe; selects still decode.
        BA = 16'h9E00; BRWn = 1'b0; ce2Hd = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_strb", {22'd0, strb_vec()}, {22'd0, 10'h3FF});
        check("reset_comb", {22'd0, comb_vec()}, {22'd0, 10'b0111011111});
        @(negedge clk);
        ce2Hd = 1'b0; BRWn = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        do_read(16'h8000, 10'b0111001111);
        do_read(16'h9000, 10'b0111010111);
        do_read(16'h93FF, 10'b0111010111);
        do_read(16'h9600, 10'b0111011011);
        do_read(16'h9A05, 10'b0111011101);
        do_read(16'hA000, 10'b1011111111);
        do_read(16'hC000, 10'b1101111111);
        do_read(16'hFFFF, 10'b1110111111);
        do_read(16'h9C80, 10'b0111011111);
        do_read(16'h0000, 10'b0111111111);
        do_read(16'h0002, 10'b0111111110);
        do_read(16'h7FFF, 10'b0111111111);

        do_write(16'h9C80, 6);
        do_write(16'h0000, 2);
        do_write(16'h0001, 1);
        do_write(16'h0002, NoStrb);
        check("bitmd_wr", {31'd0, BITMDn}, 32'd0);
        do_write(16'h9E00, 9);
        do_write(16'h9D80, 8);
        do_write(16'h9F85, 3);
        do_write(16'h9EC3, 5);
        do_write(16'h9D00, 7);
        do_write(16'h9F7F, 4);
        do_write(16'h0003, NoStrb);
        do_write(16'h7FFF, NoStrb);
        do_write(16'h9800, NoStrb);

        // ce2Hd low: write must not strobe.
        @(negedge clk);
        BA = 16'h9C80; BRWn = 1'b0; ce2Hd = 1'b0;
        @(posedge clk); #1;
        check("no_ce2hd", {22'd0, strb_vec()}, {22'd0, 10'h3FF});

        // Reset mid-strobe aborts it immediately.
        @(negedge clk);
        BA = 16'h9E00; BRWn = 1'b0; ce2Hd = 1'b1;
        @(posedge clk); #1;
        check("pre_abort", {31'd0, WDOGn}, 32'd0);
        ce2Hd = 1'b0;
        #10 reset_n = 1'b0;
        #1 check("abort", {22'd0, strb_vec()}, {22'd0, 10'h3FF});
        check("comb_in_reset", {22'd0, comb_vec()}, {22'd0, 10'b0111011111});
        @(negedge clk);
        reset_n = 1'b1;

        do_write(16'h9C80, 6);
        do_write(16'h9C00, UartIdx);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/address_decoder.md
ADDRESS_DECODER -- requirements
Module: address_decoder

Interface
REQ-001 clk  input  1  system clock, 10 MHz.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 ce2H  input  1  CPU phase clock-enable; accepted for interface compatibility, has no effect on any output.
REQ-004 ce2Hd  input  1  delayed CPU phase clock-enable, one clk wide; qualifies all write strobes.
REQ-005 BA  input  16  CPU address bus.
REQ-006 BRWn  input  1  CPU read/write: 1 = read, 0 = write.
REQ-007 NRn, ROM0n, ROM1n, ROM2n, SBUSn, SRAMn, NVRAMn, IN0n, CIOn, BITMDn  output  1 each  combinational selects.
REQ-008 WDOGn, INTACKn, VSLDn, HSLDn, OUT0n, OUT1n, CRAMn, XCOORDn, YCOORDn, UARTn  output  1 each  registered write strobes, active-low.

Function
REQ-009 NRn SHALL be 1 for BA in A000-FFFF and 0 otherwise (active-high ROM region flag).
REQ-010 ROM0n low for A000-BFFF, ROM1n low for C000-DFFF, ROM2n low for E000-FFFF; otherwise high.
REQ-011 SBUSn SHALL be low for 8000-9FFF.
REQ-012 SRAMn SHALL be low for 8000-8FFF.
REQ-013 NVRAMn SHALL be low for 9000-93FF; BA[9:8] are don't-care (256-byte mirror).
REQ-014 IN0n SHALL be low for 9400-97FF; BA[9] is passed through for sub-selection downstream.
REQ-015 CIOn SHALL be low for 9800-9BFF, for reads and writes.
REQ-016 BITMDn SHALL be low for BA = 0002, for reads and writes.
REQ-017 All combinational selects SHALL ignore BRWn, except as stated in REQ-016, and SHALL NOT depend on ce2H or ce2Hd.
REQ-018 Each write strobe SHALL have a decode window: UARTn 9C00-9C7F; HSLDn 9C80-9CFF; VSLDn 9D00-9D7F; INTACKn 9D80-9DFF; WDOGn 9E00-9E7F; OUT0n 9E80-9EFF; OUT1n 9F00-9F7F; CRAMn 9F80-9FFF; XCOORDn BA = 0000; YCOORDn BA = 0001.
REQ-019 A strobe SHALL go low for exactly one clk, starting at the clk edge where ce2Hd = 1, BRWn = 0 and BA is inside its decode window.
REQ-020 On every other clk edge, each strobe SHALL return high, so back-to-back strobes are separated by at least one high cycle whenever ce2Hd is non-consecutive.
REQ-021 Reads SHALL never assert a write strobe.
REQ-022 At most one write strobe SHALL be low in any cycle, because the decode windows are disjoint.
REQ-023 An address outside every defined window (e.g. 0003-7FFF for strobes) SHALL assert no strobe.
REQ-024 Decoding SHALL use only the address bits needed to select a window; the remaining low bits are don't-care, and the mirrors listed above are intentional.

Reset
REQ-025 While reset_n = 0, every registered strobe SHALL be forced high asynchronously.
REQ-026 The first strobe after reset SHALL be produced by the first qualifying ce2Hd edge after reset_n rises.
REQ-027 A strobe in progress when reset asserts SHALL be aborted immediately.
REQ-028 Combinational selects SHALL follow BA regardless of reset.

Configuration
REQ-029 Macro ADDRDEC_UART_EN: when defined, UARTn SHALL decode 9C00-9C7F per REQ-018/019.
REQ-030 When ADDRDEC_UART_EN is not defined, UARTn SHALL be tied high permanently, with no decode logic.

Verification
REQ-031 Read sweep of 8000, 9000, 93FF, 9600, 9A05, A000, C000, FFFF -> exactly SRAMn, NVRAMn, NVRAMn, IN0n, CIOn, ROM0n, ROM1n, ROM2n low respectively; NRn = 1 only for A000-FFFF; no strobes.
REQ-032 Write to 9C80 with ce2Hd pulsed -> HSLDn low for exactly 1 clk after that edge; the same access with BRWn = 1 -> HSLDn stays high.
REQ-033 Writes to 0000, 0001, 0002 -> XCOORDn pulse, then YCOORDn pulse, then BITMDn low combinationally with no strobe.
REQ-034 Writes to 9E00, 9D80, 9F85, 9EC3 -> WDOGn, INTACKn, CRAMn, OUT0n single-clk pulses respectively.
REQ-035 Assert reset_n = 0 mid-strobe -> strobe high immediately; write to 9C00 -> UARTn pulses only when built with ADDRDEC_UART_EN, else UARTn remains 1.
